// File: rtl/xbar_slave_write_arbiter_if.sv
// Write-path arbitration bundle between the crossbar master-side FIFOs and
// one slave port. The "slave" modport is the arbiter's view, the "master"
// modport is the view of the surrounding FIFOs that feed and drain it.
interface xbar_slave_write_arbiter_if #(
  parameter int masters = 2,
  parameter int slaves  = 2
);
  localparam int MW = (masters > 1) ? $clog2(masters) : 1;
  localparam int DW = (slaves > 1) ? $clog2(slaves) : 1;

  // per-master AW FIFO front status
  logic          master_aw_empty [0:masters-1];
  logic [DW-1:0] master_aw_dest  [0:masters-1];

  // per-master W FIFO front status
  logic          master_w_empty  [0:masters-1];
  logic [DW-1:0] master_w_dest   [0:masters-1];
  logic          master_wlast    [0:masters-1];

  // this slave's FIFO fill status
  logic          slave_aw_fifo_full;
  logic          slave_w_fifo_full;

  // strobes and selects produced by the arbiter
  logic          master_aw_pop   [0:masters-1];
  logic          master_w_pop    [0:masters-1];
  logic          slave_aw_push;
  logic          slave_w_push;
  logic [MW-1:0] aw_sel_master;
  logic [MW-1:0] w_sel_master;
  logic          busy;

  modport slave (
    input  master_aw_empty, master_aw_dest,
    input  master_w_empty, master_w_dest, master_wlast,
    input  slave_aw_fifo_full, slave_w_fifo_full,
    output master_aw_pop, master_w_pop,
    output slave_aw_push, slave_w_push,
    output aw_sel_master, w_sel_master, busy
  );

  modport master (
    output master_aw_empty, master_aw_dest,
    output master_w_empty, master_w_dest, master_wlast,
    output slave_aw_fifo_full, slave_w_fifo_full,
    input  master_aw_pop, master_w_pop,
    input  slave_aw_push, slave_w_push,
    input  aw_sel_master, w_sel_master, busy
  );
endinterface

// File: rtl/xbar_slave_write_arbiter.sv
// Slave-side write arbiter of the crossbar, one instance per slave port.
// Grants one AW at a time round-robin among masters whose AW targets this
// slave, then locks the W channel to that master until its WLAST beat has
// been pushed. Only a single write burst is ever in flight on this port.
module xbar_slave_write_arbiter #(
  parameter int masters           = 2,
  parameter int slaves            = 2,
  parameter int i_am_slave_number = 0
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  xbar_slave_write_arbiter_if.slave   bus
);

  localparam int MW = (masters > 1) ? $clog2(masters) : 1;
  localparam int DW = (slaves > 1) ? $clog2(slaves) : 1;
  localparam logic [DW-1:0] MY_DEST = DW'(i_am_slave_number);
  localparam logic [MW-1:0] LAST_M  = MW'(masters - 1);
  localparam logic [MW:0]   N_M     = (MW + 1)'(masters);

  typedef enum logic {
    ST_IDLE,
    ST_DATA
  } state_e;

  state_e         state_q, state_d;
  logic [MW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [MW-1:0]  owner_q, owner_d;

  logic [masters-1:0] req;
  logic               any_req;
  logic [MW-1:0]      winner;
  logic [MW:0]        search_idx;
  logic               w_valid;
  logic [masters-1:0] aw_pop_vec;
  logic [masters-1:0] w_pop_vec;
  logic               aw_push;
  logic               w_push;

  // A master requests when its AW front is present and decoded to this slave
  always_comb begin
    req = '0;
    for (int m = 0; m < masters; m++) begin
      req[m] = ~bus.master_aw_empty[m] & (bus.master_aw_dest[m] == MY_DEST);
    end
  end

  // Round-robin search: first requester at or above rr_ptr, wrapping modulo masters
  always_comb begin
    any_req    = 1'b0;
    winner     = '0;
    search_idx = '0;
    for (int i = 0; i < masters; i++) begin
      search_idx = {1'b0, rr_ptr_q} + (MW + 1)'(i);
      if (search_idx >= N_M) begin
        search_idx = search_idx - N_M;
      end
      if (!any_req && req[search_idx[MW-1:0]]) begin
        any_req = 1'b1;
        winner  = search_idx[MW-1:0];
      end
    end
  end

  // Next-state logic: AW handshake in IDLE, owner-locked W beats in DATA
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    aw_pop_vec = '0;
    w_pop_vec  = '0;
    aw_push    = 1'b0;
    w_push     = 1'b0;
    w_valid    = ~bus.master_w_empty[owner_q] &
                 (bus.master_w_dest[owner_q] == MY_DEST);

    unique case (state_q)
      ST_IDLE: begin
        // a full AW FIFO simply holds the grant; rr_ptr is left alone so the
        // same winner is picked again once space appears
        if (any_req && !bus.slave_aw_fifo_full) begin
          aw_push            = 1'b1;
          aw_pop_vec[winner] = 1'b1;
          owner_d            = winner;
          state_d            = ST_DATA;
        end
      end
      ST_DATA: begin
        // stalls here as long as needed; the burst is never timed out
        if (w_valid && !bus.slave_w_fifo_full) begin
          w_push              = 1'b1;
          w_pop_vec[owner_q]  = 1'b1;
          if (bus.master_wlast[owner_q]) begin
            state_d  = ST_IDLE;
            rr_ptr_d = (owner_q == LAST_M) ? '0 : owner_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Drive outputs; strobes are forced low while reset is asserted
  always_comb begin
    for (int m = 0; m < masters; m++) begin
      bus.master_aw_pop[m] = ARESETn & aw_pop_vec[m];
      bus.master_w_pop[m]  = ARESETn & w_pop_vec[m];
    end
    bus.slave_aw_push = ARESETn & aw_push;
    bus.slave_w_push  = ARESETn & w_push;
    bus.aw_sel_master = ARESETn ? winner : '0;
    bus.w_sel_master  = owner_q;
    bus.busy          = ARESETn & (state_q == ST_DATA);
  end

  // State, round-robin pointer and W owner registers
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

  // Pop strobes are one-hot at most and AW/W pops never coincide
  always_ff @(posedge ACLK) begin
    if (ARESETn) begin
      assert ($onehot0(aw_pop_vec));
      assert ($onehot0(w_pop_vec));
      assert (!((|aw_pop_vec) && (|w_pop_vec)));
    end
  end

endmodule

// File: tb/tb_xbar_slave_write_arbiter.sv
// Directed bench for xbar_slave_write_arbiter with two masters, two slaves,
// instance acting as slave 0. Inputs change on the falling edge; outputs are
// sampled 1 ns later, well away from the rising edge.
module tb_xbar_slave_write_arbiter;

  logic clk;
  logic arst_n;
  int   n_compared;
  int   n_mismatch;

  xbar_slave_write_arbiter_if #(.masters(2), .slaves(2)) bus ();

  xbar_slave_write_arbiter #(
    .masters(2),
    .slaves(2),
    .i_am_slave_number(0)
  ) dut (
    .ACLK(clk),
    .ARESETn(arst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // packed view: {aw_pop1, aw_pop0, w_pop1, w_pop0, aw_push, w_push, busy}
  function automatic logic [6:0] obs();
    return {bus.master_aw_pop[1], bus.master_aw_pop[0],
            bus.master_w_pop[1], bus.master_w_pop[0],
            bus.slave_aw_push, bus.slave_w_push, bus.busy};
  endfunction

  task automatic set_idle();
    for (int m = 0; m < 2; m++) begin
      bus.master_aw_empty[m] = 1'b1;
      bus.master_aw_dest[m]  = 1'b0;
      bus.master_w_empty[m]  = 1'b1;
      bus.master_w_dest[m]   = 1'b0;
      bus.master_wlast[m]    = 1'b0;
    end
    bus.slave_aw_fifo_full = 1'b0;
    bus.slave_w_fifo_full  = 1'b0;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    set_idle();
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [6:0] o;
    arst_n = 1'b0;
    for (int m = 0; m < 2; m++) begin
      bus.master_aw_empty[m] = 1'b0;
      bus.master_aw_dest[m]  = 1'b0;
      bus.master_w_empty[m]  = 1'b0;
      bus.master_w_dest[m]   = 1'b0;
      bus.master_wlast[m]    = 1'b1;
    end
    bus.slave_aw_fifo_full = 1'b0;
    bus.slave_w_fifo_full  = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      o = obs();
      n_compared++;
      if (o !== 7'b0000000) begin
        n_mismatch++;
        $display("[TB] FAIL reset_outputs[%0d]: got %b expected %b", c, o, 7'b0000000);
      end
      @(negedge clk);
    end
    arst_n = 1'b1;
    #1;
    o = obs();
    n_compared++;
    if (o !== 7'b0100100) begin
      n_mismatch++;
      $display("[TB] FAIL reset_first_grant: got %b expected %b", o, 7'b0100100);
    end
    n_compared++;
    if (bus.aw_sel_master !== 1'b0) begin
      n_mismatch++;
      $display("[TB] FAIL reset_first_sel: got %0d expected 0", bus.aw_sel_master);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [6:0] o;
    logic [6:0] exp_v;
    int         m;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      bus.master_aw_empty[k] = 1'b0;
      bus.master_w_empty[k]  = 1'b0;
      bus.master_wlast[k]    = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      m = i % 2;
      exp_v = (m == 0) ? 7'b0100100 : 7'b1000100;
      #1;
      o = obs();
      n_compared++;
      if (o !== exp_v || bus.aw_sel_master !== 1'(m)) begin
        n_mismatch++;
        $display("[TB] FAIL rr_grant[%0d]: got %b sel %0d expected %b sel %0d",
                 i, o, bus.aw_sel_master, exp_v, m);
      end
      @(negedge clk);
      exp_v = (m == 0) ? 7'b0001011 : 7'b0010011;
      #1;
      o = obs();
      n_compared++;
      if (o !== exp_v || bus.w_sel_master !== 1'(m)) begin
        n_mismatch++;
        $display("[TB] FAIL rr_wbeat[%0d]: got %b sel %0d expected %b sel %0d",
                 i, o, bus.w_sel_master, exp_v, m);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_burst_lock();
    logic [6:0] o;
    do_reset();
    bus.master_aw_empty[0] = 1'b0;
    bus.master_w_empty[0]  = 1'b0;
    #1;
    o = obs();
    n_compared++;
    if (o !== 7'b0100100) begin
      n_mismatch++;
      $display("[TB] FAIL lock_grant0: got %b expected %b", o, 7'b0100100);
    end
    @(negedge clk);
    bus.master_aw_empty[1] = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bus.master_wlast[0] = (b == 3);
      #1;
      o = obs();
      n_compared++;
      if (o !== 7'b0001011) begin
        n_mismatch++;
        $display("[TB] FAIL lock_beat[%0d]: got %b expected %b", b, o, 7'b0001011);
      end
      @(negedge clk);
    end
    bus.master_wlast[0] = 1'b0;
    #1;
    o = obs();
    n_compared++;
    if (o !== 7'b1000100 || bus.aw_sel_master !== 1'b1) begin
      n_mismatch++;
      $display("[TB] FAIL lock_grant1: got %b sel %0d expected %b sel 1",
               o, bus.aw_sel_master, 7'b1000100);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [6:0] o;
    do_reset();
    bus.master_aw_empty[1] = 1'b0;
    bus.slave_aw_fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      o = obs();
      n_compared++;
      if (o !== 7'b0000000 || bus.aw_sel_master !== 1'b1) begin
        n_mismatch++;
        $display("[TB] FAIL bp_hold[%0d]: got %b sel %0d expected %b sel 1",
                 c, o, bus.aw_sel_master, 7'b0000000);
      end
      @(negedge clk);
    end
    bus.slave_aw_fifo_full = 1'b0;
    #1;
    o = obs();
    n_compared++;
    if (o !== 7'b1000100) begin
      n_mismatch++;
      $display("[TB] FAIL bp_release: got %b expected %b", o, 7'b1000100);
    end
    @(negedge clk);
    bus.master_aw_empty[1] = 1'b1;
    bus.master_w_empty[1]  = 1'b0;
    bus.master_wlast[1]    = 1'b1;
    #1;
    o = obs();
    n_compared++;
    if (o !== 7'b0010011 || bus.w_sel_master !== 1'b1) begin
      n_mismatch++;
      $display("[TB] FAIL bp_wbeat: got %b sel %0d expected %b sel 1",
               o, bus.w_sel_master, 7'b0010011);
    end
    @(negedge clk);
  endtask

  task automatic test_w_stall();
    logic [6:0] o;
    logic [6:0] exp_v;
    int         pushes;
    pushes = 0;
    do_reset();
    bus.master_aw_empty[0] = 1'b0;
    bus.master_w_empty[0]  = 1'b0;
    #1;
    o = obs();
    n_compared++;
    if (o !== 7'b0100100) begin
      n_mismatch++;
      $display("[TB] FAIL stall_grant: got %b expected %b", o, 7'b0100100);
    end
    @(negedge clk);
    bus.master_aw_empty[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.slave_w_fifo_full = (k % 2 == 0);
      bus.master_wlast[0]   = (k == 5);
      exp_v = (k % 2 == 0) ? 7'b0000001 : 7'b0001011;
      #1;
      o = obs();
      if (o[1] === 1'b1) pushes++;
      n_compared++;
      if (o !== exp_v) begin
        n_mismatch++;
        $display("[TB] FAIL stall_cycle[%0d]: got %b expected %b", k, o, exp_v);
      end
      @(negedge clk);
    end
    bus.slave_w_fifo_full = 1'b0;
    bus.master_wlast[0]   = 1'b0;
    #1;
    o = obs();
    n_compared++;
    if (o !== 7'b0000000) begin
      n_mismatch++;
      $display("[TB] FAIL stall_idle: got %b expected %b", o, 7'b0000000);
    end
    n_compared++;
    if (pushes != 3) begin
      n_mismatch++;
      $display("[TB] FAIL stall_push_count: got %0d expected 3", pushes);
    end
    @(negedge clk);
  endtask

  task automatic test_dest_filter();
    logic [6:0] o;
    do_reset();
    bus.master_aw_empty[0] = 1'b0;
    bus.master_aw_dest[0]  = 1'b1;
    bus.master_aw_empty[1] = 1'b0;
    bus.master_aw_dest[1]  = 1'b0;
    #1;
    o = obs();
    n_compared++;
    if (o !== 7'b1000100 || bus.aw_sel_master !== 1'b1) begin
      n_mismatch++;
      $display("[TB] FAIL dest_grant1: got %b sel %0d expected %b sel 1",
               o, bus.aw_sel_master, 7'b1000100);
    end
    @(negedge clk);
    bus.master_aw_empty[1] = 1'b1;
    bus.master_w_empty[1]  = 1'b0;
    bus.master_w_dest[1]   = 1'b1;
    bus.master_wlast[1]    = 1'b1;
    #1;
    o = obs();
    n_compared++;
    if (o !== 7'b0000001) begin
      n_mismatch++;
      $display("[TB] FAIL dest_w_wrong: got %b expected %b", o, 7'b0000001);
    end
    @(negedge clk);
    bus.master_w_dest[1] = 1'b0;
    #1;
    o = obs();
    n_compared++;
    if (o !== 7'b0010011) begin
      n_mismatch++;
      $display("[TB] FAIL dest_w_right: got %b expected %b", o, 7'b0010011);
    end
    @(negedge clk);
    bus.master_w_empty[1] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      o = obs();
      n_compared++;
      if (o !== 7'b0000000 || bus.aw_sel_master !== 1'b0) begin
        n_mismatch++;
        $display("[TB] FAIL dest_never0[%0d]: got %b sel %0d expected %b sel 0",
                 c, o, bus.aw_sel_master, 7'b0000000);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    n_compared = 0;
    n_mismatch = 0;
    arst_n     = 1'b0;
    set_idle();
    test_reset();
    test_round_robin();
    test_burst_lock();
    test_backpressure();
    test_w_stall();
    test_dest_filter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
